keypad_event_decoder: RTL

KEYPAD_EVENT_DECODER -- requirements
Module: keypad_event_decoder

---
 rtl/keypad_pkg.sv | 54 +++++
 rtl/keypad_row_sync.sv | 30 +++
 rtl/keypad_event_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, key map, key codes and event helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE      = 2'd0,
    EV_DIGIT     = 2'd1,
    EV_ENTER     = 2'd2,
    EV_BACKSPACE = 2'd3
  } event_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Indexed by {row, col}; entry 0 is row 0 / column 0 ('1').
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,
    4'hC, 4'h9,     4'h8, 4'h7,
    4'hB, 4'h6,     4'h5, 4'h4,
    4'hA, 4'h3,     4'h2, 4'h1
  };

  function automatic logic [2:0] low_count(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic event_e key_event(input logic [3:0] code);
    if (code <= 4'd9)     return EV_DIGIT;
    if (code == KEY_HASH) return EV_ENTER;
    if (code == KEY_STAR) return EV_BACKSPACE;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Idle (all-ones) after reset so no phantom key is seen while the chain fills.
module keypad_row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] row_sync
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_sync = sync_q;

endmodule

// File: rtl/keypad_event_decoder.sv
// 4x4 keypad scanner/debouncer emitting one-cycle digit/enter/backspace events.
// Define KEYPAD_REPEAT_EN to compile in auto-repeat of a held backspace key.
module keypad_event_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keypad_input,
  output logic       keypad_digit_pressed,
  output logic       keypad_enter_pressed,
  output logic       keypad_backspace_pressed,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_event_decoder: timing parameters must all be at least 1");
  end

  state_e            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        row_pat_q, row_pat_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        keypad_input_q, keypad_input_d;
  logic              key_held_q, key_held_d;
  logic              digit_q, digit_d;
  logic              enter_q, enter_d;
  logic              backspace_q, backspace_d;

  logic [3:0] rows_s;
  logic [2:0] n_low;
  logic       div_done;
  logic       cnt_done;
  logic       pat_match;
  logic       all_high;
  logic       accept;
  logic       release_done;
  logic [3:0] accept_code;
  logic       rep_fire;

  keypad_row_sync u_row_sync (
    .clk      (clk),
    .reset    (reset),
    .row_in   (row_in),
    .row_sync (rows_s)
  );

  assign n_low        = low_count(rows_s);
  assign div_done     = (div_q == DIV_LAST);
  assign cnt_done     = (cnt_q == CNT_LAST);
  assign pat_match    = (rows_s == row_pat_q);
  assign all_high     = &rows_s;
  assign accept       = (state_q == ST_DEBOUNCE) && pat_match && cnt_done;
  assign release_done = (state_q == ST_RELEASE) && all_high && cnt_done;
  assign accept_code  = KEY_MAP[{row_idx_q, col_idx_q}];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SCAN;
      col_idx_q      <= 2'd0;
      div_q          <= '0;
      cnt_q          <= '0;
      row_pat_q      <= 4'hF;
      row_idx_q      <= 2'd0;
      keypad_input_q <= 4'h0;
      key_held_q     <= 1'b0;
      digit_q        <= 1'b0;
      enter_q        <= 1'b0;
      backspace_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_idx_q      <= col_idx_d;
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      row_pat_q      <= row_pat_d;
      row_idx_q      <= row_idx_d;
      keypad_input_q <= keypad_input_d;
      key_held_q     <= key_held_d;
      digit_q        <= digit_d;
      enter_q        <= enter_d;
      backspace_q    <= backspace_d;
    end
  end

  // Multiple low rows in one column is ghosting: skip it rather than guess a key.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: begin
        if (div_done && n_low == 3'd1) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!pat_match)    state_d = ST_SCAN;
        else if (cnt_done) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (all_high) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!all_high)     state_d = ST_HELD;
        else if (cnt_done) state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    col_idx_d = col_idx_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    row_pat_d = row_pat_q;
    row_idx_d = row_idx_q;
    case (state_q)
      ST_SCAN: begin
        cnt_d = '0;
        if (div_done) begin
          div_d = '0;
          if (n_low == 3'd1) begin
            row_pat_d = rows_s;
            row_idx_d = low_row_idx(rows_s);
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!pat_match) begin
          div_d = '0;
          cnt_d = '0;
        end else if (cnt_done) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        cnt_d = '0;
      end
      ST_RELEASE: begin
        if (!all_high) begin
          cnt_d = '0;
        end else if (cnt_done) begin
          cnt_d     = '0;
          div_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
        div_d = '0;
      end
    endcase
  end

  always_comb begin
    digit_d        = 1'b0;
    enter_d        = 1'b0;
    backspace_d    = rep_fire;
    keypad_input_d = keypad_input_q;
    key_held_d     = key_held_q;
    if (accept) begin
      keypad_input_d = accept_code;
      key_held_d     = 1'b1;
      case (key_event(accept_code))
        EV_DIGIT:     digit_d     = 1'b1;
        EV_ENTER:     enter_d     = 1'b1;
        EV_BACKSPACE: backspace_d = 1'b1;
        default:      ;
      endcase
    end else if (release_done) begin
      key_held_d = 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_armed_q, rep_armed_d;
  logic             rep_fire_d;

  // First repeat waits the long delay; once armed, the short period applies until release.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire_d  = 1'b0;
    if (accept) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (state_q == ST_HELD && keypad_input_q == KEY_STAR) begin
      if (rep_cnt_q == (rep_armed_q ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
        rep_fire_d  = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else if (rep_cnt_q != {REP_W{1'b1}}) begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign rep_fire = rep_fire_d;
`else
  assign rep_fire = 1'b0;
`endif

  assign col_out                  = ~(4'b0001 << col_idx_q);
  assign keypad_input             = keypad_input_q;
  assign key_held                 = key_held_q;
  assign keypad_digit_pressed     = digit_q;
  assign keypad_enter_pressed     = enter_q;
  assign keypad_backspace_pressed = backspace_q;

endmodule
